// File: rtl/motor_mixer_if.sv
// Bundle of command inputs, handshake flags and motor outputs between the
// rate PID stage, the mixer and the PWM generator.
interface motor_mixer_if;
  logic [7:0]  throttle;
  logic [15:0] roll_rate;
  logic [15:0] pitch_rate;
  logic [15:0] yaw_rate;
  logic        armed;
  logic        start_flag;
  logic        wait_flag;
  logic [7:0]  motor_1;
  logic [7:0]  motor_2;
  logic [7:0]  motor_3;
  logic [7:0]  motor_4;
  logic        mix_active;
  logic        mix_complete;

  modport master (
    output throttle, roll_rate, pitch_rate, yaw_rate, armed, start_flag, wait_flag,
    input  motor_1, motor_2, motor_3, motor_4, mix_active, mix_complete
  );

  modport slave (
    input  throttle, roll_rate, pitch_rate, yaw_rate, armed, start_flag, wait_flag,
    output motor_1, motor_2, motor_3, motor_4, mix_active, mix_complete
  );
endinterface

// File: rtl/motor_mixer.sv
// Quad-X motor mixer: latches throttle and PID rates on start, scales, mixes,
// clamps and holds four registered motor commands until released by wait_flag.
module motor_mixer #(
  parameter logic [7:0]  MOTOR_MIN  = 8'd0,
  parameter logic [7:0]  MOTOR_MAX  = 8'd255,
  parameter int unsigned RATE_SHIFT = 6
) (
  input  logic         us_clk,
  input  logic         resetn,
  motor_mixer_if.slave bus
);

  typedef enum logic [5:0] {
    ST_WAIT     = 6'b000001,
    ST_LATCH    = 6'b000010,
    ST_SCALE    = 6'b000100,
    ST_SUM      = 6'b001000,
    ST_CLAMP    = 6'b010000,
    ST_COMPLETE = 6'b100000
  } state_t;

  localparam logic signed [17:0] MIN_S = {10'd0, MOTOR_MIN};
  localparam logic signed [17:0] MAX_S = {10'd0, MOTOR_MAX};

  state_t state_q, state_d;

  logic [7:0]         thr_q, thr_d;
  logic [15:0]        roll_q, roll_d, pitch_q, pitch_d, yaw_q, yaw_d;
  logic               armed_q, armed_d;
  logic signed [17:0] t_q, t_d, r_q, r_d, p_q, p_d, y_q, y_d;
  logic signed [17:0] m1_q, m1_d, m2_q, m2_d, m3_q, m3_d, m4_q, m4_d;
  logic [7:0]         mot1_q, mot1_d, mot2_q, mot2_d, mot3_q, mot3_d, mot4_q, mot4_d;
  logic               active_q, active_d, complete_q, complete_d;

  // Sign-extend first so the arithmetic shift floors toward -inf.
  function automatic logic signed [17:0] scale_rate(input logic [15:0] rate);
    logic signed [17:0] ext;
    ext = {{2{rate[15]}}, rate};
    return ext >>> RATE_SHIFT;
  endfunction

  function automatic logic [7:0] clamp_motor(input logic signed [17:0] v);
    logic [7:0] res;
    if (v < MIN_S) begin
      res = MOTOR_MIN;
    end else if (v > MAX_S) begin
      res = MOTOR_MAX;
    end else begin
      res = v[7:0];
    end
    return res;
  endfunction

  // Next-state, datapath and registered-output values for each mix phase.
  always_comb begin
    state_d    = state_q;
    thr_d      = thr_q;
    roll_d     = roll_q;
    pitch_d    = pitch_q;
    yaw_d      = yaw_q;
    armed_d    = armed_q;
    t_d        = t_q;
    r_d        = r_q;
    p_d        = p_q;
    y_d        = y_q;
    m1_d       = m1_q;
    m2_d       = m2_q;
    m3_d       = m3_q;
    m4_d       = m4_q;
    mot1_d     = mot1_q;
    mot2_d     = mot2_q;
    mot3_d     = mot3_q;
    mot4_d     = mot4_q;
    active_d   = active_q;
    complete_d = complete_q;

    case (state_q)
      ST_WAIT: begin
        complete_d = 1'b0;
        if (bus.start_flag) begin
          state_d  = ST_LATCH;
          active_d = 1'b1;
        end else begin
          active_d = 1'b0;
        end
      end
      ST_LATCH: begin
        thr_d   = bus.throttle;
        roll_d  = bus.roll_rate;
        pitch_d = bus.pitch_rate;
        yaw_d   = bus.yaw_rate;
        armed_d = bus.armed;
        state_d = ST_SCALE;
      end
      ST_SCALE: begin
        t_d     = {10'd0, thr_q};
        r_d     = scale_rate(roll_q);
        p_d     = scale_rate(pitch_q);
        y_d     = scale_rate(yaw_q);
        state_d = ST_SUM;
      end
      ST_SUM: begin
        m1_d    = t_q + p_q + r_q - y_q;
        m2_d    = t_q + p_q - r_q + y_q;
        m3_d    = t_q - p_q - r_q - y_q;
        m4_d    = t_q - p_q + r_q + y_q;
        state_d = ST_CLAMP;
      end
      ST_CLAMP: begin
        if (armed_q) begin
          mot1_d = clamp_motor(m1_q);
          mot2_d = clamp_motor(m2_q);
          mot3_d = clamp_motor(m3_q);
          mot4_d = clamp_motor(m4_q);
        end else begin
          mot1_d = 8'd0;
          mot2_d = 8'd0;
          mot3_d = 8'd0;
          mot4_d = 8'd0;
        end
        complete_d = 1'b1;
        state_d    = ST_COMPLETE;
      end
      ST_COMPLETE: begin
        if (bus.wait_flag) begin
          state_d    = ST_WAIT;
          active_d   = 1'b0;
          complete_d = 1'b0;
        end else begin
          state_d = ST_COMPLETE;
        end
      end
      default: begin
        state_d    = ST_WAIT;
        active_d   = 1'b0;
        complete_d = 1'b0;
      end
    endcase
  end

  // State, captured operands, pipeline values and outputs with async reset.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_WAIT;
      thr_q      <= 8'd0;
      roll_q     <= 16'd0;
      pitch_q    <= 16'd0;
      yaw_q      <= 16'd0;
      armed_q    <= 1'b0;
      t_q        <= 18'sd0;
      r_q        <= 18'sd0;
      p_q        <= 18'sd0;
      y_q        <= 18'sd0;
      m1_q       <= 18'sd0;
      m2_q       <= 18'sd0;
      m3_q       <= 18'sd0;
      m4_q       <= 18'sd0;
      mot1_q     <= 8'd0;
      mot2_q     <= 8'd0;
      mot3_q     <= 8'd0;
      mot4_q     <= 8'd0;
      active_q   <= 1'b0;
      complete_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      thr_q      <= thr_d;
      roll_q     <= roll_d;
      pitch_q    <= pitch_d;
      yaw_q      <= yaw_d;
      armed_q    <= armed_d;
      t_q        <= t_d;
      r_q        <= r_d;
      p_q        <= p_d;
      y_q        <= y_d;
      m1_q       <= m1_d;
      m2_q       <= m2_d;
      m3_q       <= m3_d;
      m4_q       <= m4_d;
      mot1_q     <= mot1_d;
      mot2_q     <= mot2_d;
      mot3_q     <= mot3_d;
      mot4_q     <= mot4_d;
      active_q   <= active_d;
      complete_q <= complete_d;
    end
  end

  assign bus.motor_1      = mot1_q;
  assign bus.motor_2      = mot2_q;
  assign bus.motor_3      = mot3_q;
  assign bus.motor_4      = mot4_q;
  assign bus.mix_active   = active_q;
  assign bus.mix_complete = complete_q;

endmodule

// File: tb/tb_motor_mixer.sv
// Randomized self-checking bench for motor_mixer against a behavioural quad-X
// mixing model computed with plain integer arithmetic.
module tb_motor_mixer;

  logic us_clk = 1'b0;
  logic resetn = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  motor_mixer_if bus();

  motor_mixer dut (
    .us_clk (us_clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 us_clk = ~us_clk;

  // Quad-X sign table, motors front-left, front-right, rear-right, rear-left.
  localparam int ROLL_SGN[4]  = '{1, -1, -1, 1};
  localparam int PITCH_SGN[4] = '{1, 1, -1, -1};
  localparam int YAW_SGN[4]   = '{-1, 1, -1, 1};

  task automatic check_val(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int floor_div64(input int v);
    if (v >= 0) return v / 64;
    return -((-v + 63) / 64);
  endfunction

  function automatic int ref_motor(input int idx, input int thr, input logic [15:0] r,
                                   input logic [15:0] p, input logic [15:0] y, input bit arm);
    int m;
    if (!arm) return 0;
    m = thr + ROLL_SGN[idx]  * floor_div64(int'($signed(r)))
            + PITCH_SGN[idx] * floor_div64(int'($signed(p)))
            + YAW_SGN[idx]   * floor_div64(int'($signed(y)));
    if (m < 0) return 0;
    if (m > 255) return 255;
    return m;
  endfunction

  function automatic int motor_out(input int idx);
    case (idx)
      0:       return int'(bus.motor_1);
      1:       return int'(bus.motor_2);
      2:       return int'(bus.motor_3);
      default: return int'(bus.motor_4);
    endcase
  endfunction

  task automatic scramble_inputs();
    bus.throttle   = 8'($urandom);
    bus.roll_rate  = 16'($urandom);
    bus.pitch_rate = 16'($urandom);
    bus.yaw_rate   = 16'($urandom);
    bus.armed      = 1'($urandom);
  endtask

  // One full mix transaction; inputs are scrambled right after the latch edge.
  task automatic do_mix(input string tag, input logic [7:0] thr, input logic [15:0] r,
                        input logic [15:0] p, input logic [15:0] y, input bit arm,
                        input bit collide);
    int exp[4];
    int n;
    for (int i = 0; i < 4; i++) exp[i] = ref_motor(i, int'(thr), r, p, y, arm);
    @(negedge us_clk);
    bus.throttle   = thr;
    bus.roll_rate  = r;
    bus.pitch_rate = p;
    bus.yaw_rate   = y;
    bus.armed      = arm;
    bus.start_flag = 1'b1;
    @(posedge us_clk); #1;
    check_val({tag, "/active_e0"}, int'(bus.mix_active), 1);
    check_val({tag, "/complete_e0"}, int'(bus.mix_complete), 0);
    bus.start_flag = 1'b0;
    @(posedge us_clk); #1;
    scramble_inputs();
    n = 1;
    while (bus.mix_complete !== 1'b1 && n < 12) begin
      @(posedge us_clk); #1;
      n++;
    end
    check_val({tag, "/latency"}, n, 4);
    for (int i = 0; i < 4; i++) check_val($sformatf("%s/motor_%0d", tag, i + 1), motor_out(i), exp[i]);
    bus.start_flag = 1'b1;
    repeat (2) @(posedge us_clk);
    #1;
    check_val({tag, "/hold_complete"}, int'(bus.mix_complete), 1);
    check_val({tag, "/hold_motor_1"}, motor_out(0), exp[0]);
    bus.start_flag = collide;
    bus.wait_flag  = 1'b1;
    @(posedge us_clk); #1;
    bus.start_flag = 1'b0;
    bus.wait_flag  = 1'b0;
    check_val({tag, "/complete_drop"}, int'(bus.mix_complete), 0);
    check_val({tag, "/active_drop"}, int'(bus.mix_active), 0);
    @(posedge us_clk); #1;
    check_val({tag, "/idle_after"}, int'(bus.mix_active), 0);
    check_val({tag, "/stable_motor_4"}, motor_out(3), exp[3]);
  endtask

  initial begin
    bit saw_complete;
    bus.start_flag = 1'b0;
    bus.wait_flag  = 1'b0;
    bus.throttle   = 8'd77;
    bus.roll_rate  = 16'h1234;
    bus.pitch_rate = 16'h0F00;
    bus.yaw_rate   = 16'h8001;
    bus.armed      = 1'b1;
    #1 resetn = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) check_val($sformatf("reset/motor_%0d", i + 1), motor_out(i), 0);
    check_val("reset/active", int'(bus.mix_active), 0);
    check_val("reset/complete", int'(bus.mix_complete), 0);
    repeat (2) @(posedge us_clk);
    @(negedge us_clk);
    resetn = 1'b1;
    repeat (5) @(posedge us_clk);
    #1;
    check_val("idle/active", int'(bus.mix_active), 0);
    check_val("idle/motor_1", motor_out(0), 0);

    do_mix("basic",     8'd100, 16'h0100, 16'h0000, 16'h0000, 1'b1, 1'b0);
    do_mix("clamp_hi",  8'd250, 16'h0000, 16'h0400, 16'h0000, 1'b1, 1'b0);
    do_mix("clamp_lo",  8'd5,   16'h0000, 16'h0000, 16'h0200, 1'b1, 1'b0);
    do_mix("neg_round", 8'd100, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0);
    do_mix("disarmed",  8'd200, 16'h0100, 16'h0040, 16'hFFC0, 1'b0, 1'b0);
    do_mix("latched",   8'd150, 16'hFF00, 16'h0080, 16'h0000, 1'b1, 1'b1);

    // Abort a mix while it sits in SUM; the old outputs are nonzero here.
    @(negedge us_clk);
    bus.throttle   = 8'd180;
    bus.roll_rate  = 16'h0200;
    bus.pitch_rate = 16'h0000;
    bus.yaw_rate   = 16'h0000;
    bus.armed      = 1'b1;
    bus.start_flag = 1'b1;
    @(posedge us_clk); #1;
    bus.start_flag = 1'b0;
    repeat (2) @(posedge us_clk);
    #1 resetn = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) check_val($sformatf("midreset/motor_%0d", i + 1), motor_out(i), 0);
    check_val("midreset/active", int'(bus.mix_active), 0);
    check_val("midreset/complete", int'(bus.mix_complete), 0);
    @(negedge us_clk);
    resetn = 1'b1;
    saw_complete = 1'b0;
    repeat (8) begin
      @(posedge us_clk); #1;
      if (bus.mix_complete === 1'b1) saw_complete = 1'b1;
    end
    check_val("midreset/no_completion", int'(saw_complete), 0);
    check_val("midreset/motor_1_after", motor_out(0), 0);

    for (int k = 0; k < 30; k++) begin
      do_mix($sformatf("rand%0d", k), 8'($urandom), 16'($urandom), 16'($urandom),
             16'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
